// File: rtl/hack_mem_pkg.sv
// Shared constants and FSM encoding for the Hack memory-map arbiter.
package hack_mem_pkg;
  localparam int          ADDR_W      = 15;
  localparam int          DATA_W      = 16;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the priority pointer moves past the last winner on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       advance,
  output logic       grant
);
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (advance) prio_d = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end

  // Priority only matters on a tie; a lone requester always wins.
  always_comb begin
    grant = prio_q;
    if (req == 2'b01)      grant = 1'b0;
    else if (req == 2'b10) grant = 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one Hack Memory port between two requesters, one access per IDLE/ACCESS/RESP round.
module mem_arbiter #(
  parameter int                ADDR_W   = hack_mem_pkg::ADDR_W,
  parameter int                DATA_W   = hack_mem_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] KBD_ADDR = ADDR_W'(hack_mem_pkg::KBD_ADDR)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);
  import hack_mem_pkg::state_e;
  import hack_mem_pkg::IDLE;
  import hack_mem_pkg::ACCESS;
  import hack_mem_pkg::RESP;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic              err_q, err_d;
  logic              arb_grant;

  rr_arb2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        ({r1_req, r0_req}),
    .last_grant (grant_q),
    .advance    (state_q == RESP),
    .grant      (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    grant_d = grant_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant_d = arb_grant;
          addr_d  = arb_grant ? r1_addr  : r0_addr;
          wdata_d = arb_grant ? r1_wdata : r0_wdata;
          we_d    = arb_grant ? r1_we    : r0_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Keyboard is readable but not writable; everything above it is unmapped.
        err_d   = we_q ? (addr_q >= KBD_ADDR) : (addr_q > KBD_ADDR);
        rdata_d = (!we_q && addr_q <= KBD_ADDR) ? mem_out : '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      grant_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      grant_q <= grant_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_load    = (state_q == ACCESS) && we_q && (addr_q < KBD_ADDR);

  assign r0_ack   = (state_q == RESP) && !grant_q;
  assign r1_ack   = (state_q == RESP) &&  grant_q;
  assign r0_rdata = r0_ack ? rdata_q : '0;
  assign r1_rdata = r1_ack ? rdata_q : '0;
  assign r0_err   = r0_ack && err_q;
  assign r1_err   = r1_ack && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed traffic against a transaction-level model of the memory map.
module tb_mem_arbiter;
  localparam logic [14:0] KBD = 15'h6000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [14:0] r0_addr = '0, r1_addr = '0;
  logic [15:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_ack, r0_err, r1_ack, r1_err, mem_load;
  logic [15:0] r0_rdata, r1_rdata, mem_in, mem_out;
  logic [14:0] mem_address;
  logic [15:0] kbd_val = 16'h0041;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  // Bench-side Hack Memory: RAM+screen below KBD, keyboard at KBD, zero above.
  logic [15:0] ram [0:32767];
  initial for (int i = 0; i < 32768; i++) ram[i] = 16'h0;
  assign mem_out = (mem_address == KBD) ? kbd_val :
                   (mem_address < KBD) ? ram[mem_address] : 16'h0;
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;

  // Reference model state.
  logic [15:0] ref_mem [logic [14:0]];
  logic        p_vld [2];
  logic        p_we  [2];
  logic [14:0] p_addr[2];
  logic [15:0] p_wd  [2];
  int          last_w;
  int          n_chk = 0, n_pass = 0;
  logic [14:0] atab [12] = '{15'h0000, 15'h0001, 15'h0002, 15'h0003, 15'h0010, 15'h1234,
                             15'h4000, 15'h4001, 15'h5FFF, 15'h6000, 15'h6001, 15'h7FFF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic drive();
    r0_req = p_vld[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wd[0];
    r1_req = p_vld[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wd[1];
  endtask

  task automatic set_req(input int r, input logic we, input logic [14:0] a, input logic [15:0] d);
    p_vld[r] = 1'b1; p_we[r] = we; p_addr[r] = a; p_wd[r] = d;
    drive();
  endtask

  task automatic rand_req(input int r);
    set_req(r, 1'($urandom_range(0, 1)), atab[$urandom_range(0, 11)], 16'($urandom));
  endtask

  // Predict the winner and its result, then wait for the ack and compare.
  task automatic run_txn();
    int w, n, loads;
    logic [14:0] a;
    logic [15:0] exp_rd;
    logic        exp_err;
    if (p_vld[0] && p_vld[1]) w = 1 - last_w;
    else                      w = p_vld[1] ? 1 : 0;
    last_w = w;
    a = p_addr[w];
    if (p_we[w]) begin
      exp_err = (a >= KBD);
      exp_rd  = 16'h0;
      if (!exp_err) ref_mem[a] = p_wd[w];
    end else begin
      exp_err = (a > KBD);
      exp_rd  = exp_err ? 16'h0 : (a == KBD ? kbd_val : ref_rd(a));
    end
    n = 0; loads = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_load) loads++;
    end while (!(r0_ack || r1_ack) && n < 8);
    chk("latency", 32'(n), 32'd3);
    chk("ack_r0", 32'(r0_ack), 32'(w == 0));
    chk("ack_r1", 32'(r1_ack), 32'(w == 1));
    chk("rdata", 32'(w ? r1_rdata : r0_rdata), 32'(exp_rd));
    chk("err", 32'(w ? r1_err : r0_err), 32'(exp_err));
    chk("other_out", 32'(w ? {r0_rdata, r0_err} : {r1_rdata, r1_err}), 32'd0);
    chk("loads", 32'(loads), 32'((p_we[w] && a < KBD) ? 1 : 0));
    @(posedge clk); #1;
    p_vld[w] = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p_vld[0] = 0; p_vld[1] = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    last_w = 1;
  endtask

  initial begin
    int acks;
    for (int r = 0; r < 2; r++) begin
      p_vld[r] = 0; p_we[r] = 0; p_addr[r] = '0; p_wd[r] = '0;
    end
    do_reset();
    @(negedge clk);
    chk("rst_out", 32'({r0_ack, r1_ack, r0_err, r1_err, mem_load}), 32'd0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 32'd0);
    chk("rst_mem", {2'b0, mem_address, mem_in}, 32'd0);
    @(posedge clk); #1;

    // Simultaneous writes: r0 first after reset, then readbacks.
    set_req(0, 1'b1, 15'h1234, 16'h04D2);
    set_req(1, 1'b1, 15'h2345, 16'h0929);
    run_txn(); run_txn();
    set_req(0, 1'b0, 15'h1234, 16'h0); run_txn();
    set_req(1, 1'b0, 15'h2345, 16'h0); run_txn();

    // Write -1 then read it back.
    set_req(0, 1'b1, 15'h0000, 16'hFFFF); run_txn();
    set_req(0, 1'b0, 15'h0000, 16'h0);    run_txn();

    // Keyboard write and unmapped read rejected, keyboard read allowed.
    set_req(1, 1'b1, 15'h6000, 16'd520); run_txn();
    set_req(1, 1'b0, 15'h6001, 16'h0);   run_txn();
    set_req(1, 1'b0, 15'h6000, 16'h0);   run_txn();

    // Both held continuously: grants must alternate.
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 2; r++) if (!p_vld[r]) set_req(r, 1'b0, 15'(r + 1), 16'h0);
      run_txn();
    end
    if (p_vld[0] || p_vld[1]) run_txn();

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < 2; r++) if (!p_vld[r] && $urandom_range(0, 3) != 0) rand_req(r);
      if (!p_vld[0] && !p_vld[1]) rand_req(int'($urandom_range(0, 1)));
      run_txn();
    end
    while (p_vld[0] || p_vld[1]) run_txn();

    // Reset in ACCESS of a screen write: the load edge coincides with the reset edge.
    set_req(0, 1'b1, 15'h4000, 16'hBEEF);
    @(posedge clk); #1;
    chk("load_scr", 32'(mem_load), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    ref_mem[15'h4000] = 16'hBEEF;
    p_vld[0] = 0; drive();
    @(negedge clk);
    chk("abort_out", 32'({r0_ack, r1_ack, r0_err, r1_err, mem_load}), 32'd0);
    chk("abort_rdata", {r0_rdata, r1_rdata}, 32'd0);
    chk("abort_mem", {2'b0, mem_address, mem_in}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    last_w = 1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (r0_ack || r1_ack || mem_load) acks++;
    end
    chk("no_ack_after_abort", 32'(acks), 32'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 15'h4000, 16'h0); run_txn();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
